multicycle_main_control: RTL and testbench

//  Multicycle main control FSM for the MIPS-subset datapath; directly upstream of ALU_Control.

---
 rtl/main_ctrl_pkg.sv | 55 +++++
 rtl/main_ctrl_decode.sv | 70 +++++++
 rtl/multicycle_main_control.sv | 117 +++++++++++
 tb/tb_multicycle_main_control.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/main_ctrl_pkg.sv
// Shared definitions for the multicycle main control FSM and its decoder:
// state encodings, opcode constants, InOp codes (also consumed by ALU_Control)
// and the packed control word driven onto the datapath.
package main_ctrl_pkg;

    localparam int unsigned STATE_W  = 4;
    localparam int unsigned OPCODE_W = 6;
    localparam int unsigned INOP_W   = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_FETCH  = 4'd0,
        ST_DECODE = 4'd1,
        ST_MEMADR = 4'd2,
        ST_MEMRD  = 4'd3,
        ST_MEMWB  = 4'd4,
        ST_MEMWR  = 4'd5,
        ST_EXEC   = 4'd6,
        ST_RWB    = 4'd7,
        ST_BRANCH = 4'd8,
        ST_JUMP   = 4'd9,
        ST_ADDIEX = 4'd10,
        ST_ADDIWB = 4'd11
    } state_e;

    localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OPCODE_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OPCODE_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OPCODE_W-1:0] OP_J     = 6'b000010;
    localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'b001000;

    localparam logic [INOP_W-1:0] ALUOP_FUNC = 3'b000;
    localparam logic [INOP_W-1:0] ALUOP_ADD  = 3'b001;
    localparam logic [INOP_W-1:0] ALUOP_SUB  = 3'b010;

    // Datapath control word decoded from the current state.
    typedef struct packed {
        logic              pc_write;
        logic              pc_write_cond;
        logic              iord;
        logic              mem_read;
        logic              mem_write;
        logic              ir_write;
        logic              mem_to_reg;
        logic              reg_dst;
        logic              reg_write;
        logic              alu_src_a;
        logic [1:0]        alu_src_b;
        logic [1:0]        pc_source;
        logic [INOP_W-1:0] in_op;
    } ctrl_word_t;

    localparam ctrl_word_t CTRL_IDLE = '0;

endpackage

// File: rtl/main_ctrl_decode.sv
// Combinational state -> control word decoder (Moore outputs).
// Ports:
//   i_state  current FSM state
//   o_ctrl   datapath control word; all zero for unreachable encodings
module main_ctrl_decode
    import main_ctrl_pkg::*;
(
    input  state_e     i_state,
    output ctrl_word_t o_ctrl
);

    always_comb begin
        o_ctrl = CTRL_IDLE;
        case (i_state)
            ST_FETCH: begin
                o_ctrl.mem_read  = 1'b1;
                o_ctrl.ir_write  = 1'b1;
                o_ctrl.alu_src_b = 2'b01;
                o_ctrl.in_op     = ALUOP_ADD;
                o_ctrl.pc_write  = 1'b1;
                o_ctrl.pc_source = 2'b00;
            end
            ST_DECODE: begin
                // Speculative branch target into ALUOut.
                o_ctrl.alu_src_b = 2'b11;
                o_ctrl.in_op     = ALUOP_ADD;
            end
            ST_MEMADR, ST_ADDIEX: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_src_b = 2'b10;
                o_ctrl.in_op     = ALUOP_ADD;
            end
            ST_MEMRD: begin
                o_ctrl.mem_read = 1'b1;
                o_ctrl.iord     = 1'b1;
            end
            ST_MEMWB: begin
                o_ctrl.reg_write  = 1'b1;
                o_ctrl.mem_to_reg = 1'b1;
            end
            ST_MEMWR: begin
                o_ctrl.mem_write = 1'b1;
                o_ctrl.iord      = 1'b1;
            end
            ST_EXEC: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.in_op     = ALUOP_FUNC;
            end
            ST_RWB: begin
                o_ctrl.reg_write = 1'b1;
                o_ctrl.reg_dst   = 1'b1;
            end
            ST_BRANCH: begin
                o_ctrl.alu_src_a     = 1'b1;
                o_ctrl.in_op         = ALUOP_SUB;
                o_ctrl.pc_write_cond = 1'b1;
                o_ctrl.pc_source     = 2'b01;
            end
            ST_JUMP: begin
                o_ctrl.pc_write  = 1'b1;
                o_ctrl.pc_source = 2'b10;
            end
            ST_ADDIWB: begin
                o_ctrl.reg_write = 1'b1;
            end
            default: o_ctrl = CTRL_IDLE;
        endcase
    end

endmodule

// File: rtl/multicycle_main_control.sv
// Multicycle MIPS-subset main control: state register, next-state logic,
// retired-instruction counter, PCEn and reset gating of all outputs.
// Ports:
//   clk, reset                      clock, async active-high reset
//   Opcode, Zero                    instruction opcode, ALU zero flag
//   PCEn .. InOp                    datapath enables/selects (Moore, PCEn also uses Zero)
//   IllegalOp                       pulse in DECODE on an unknown opcode
//   InstrCount                      retired instructions, wraps modulo 2^CNT_W
//   State                           current state encoding
module multicycle_main_control
    import main_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [5:0]        Opcode,
    input  logic              Zero,
    output logic              PCEn,
    output logic              IorD,
    output logic              MemRead,
    output logic              MemWrite,
    output logic              IRWrite,
    output logic              MemtoReg,
    output logic              RegDst,
    output logic              RegWrite,
    output logic              ALUSrcA,
    output logic [1:0]        ALUSrcB,
    output logic [1:0]        PCSource,
    output logic [2:0]        InOp,
    output logic              IllegalOp,
    output logic [CNT_W-1:0]  InstrCount,
    output logic [3:0]        State
);

    state_e             r_state;
    state_e             w_state_next;
    logic               w_illegal;
    logic               w_retire;
    logic [CNT_W-1:0]   r_count;
    ctrl_word_t         w_ctrl;
    ctrl_word_t         w_ctrl_g;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= ST_FETCH;
        else       r_state <= w_state_next;
    end

    // Next-state, illegal-opcode and retire decode.
    always_comb begin
        w_state_next = ST_FETCH;
        w_illegal    = 1'b0;
        w_retire     = 1'b0;
        case (r_state)
            ST_FETCH: w_state_next = ST_DECODE;
            ST_DECODE: begin
                case (Opcode)
                    OP_LW, OP_SW: w_state_next = ST_MEMADR;
                    OP_RTYPE:     w_state_next = ST_EXEC;
                    OP_BEQ:       w_state_next = ST_BRANCH;
                    OP_J:         w_state_next = ST_JUMP;
                    OP_ADDI:      w_state_next = ST_ADDIEX;
                    default: begin
                        w_state_next = ST_FETCH;
                        w_illegal    = 1'b1;
                    end
                endcase
            end
            // An opcode that is neither lw nor sw here is dropped without retiring.
            ST_MEMADR: begin
                if (Opcode == OP_LW)      w_state_next = ST_MEMRD;
                else if (Opcode == OP_SW) w_state_next = ST_MEMWR;
                else                      w_state_next = ST_FETCH;
            end
            ST_MEMRD:  w_state_next = ST_MEMWB;
            ST_EXEC:   w_state_next = ST_RWB;
            ST_ADDIEX: w_state_next = ST_ADDIWB;
            ST_MEMWB, ST_MEMWR, ST_RWB, ST_BRANCH, ST_JUMP, ST_ADDIWB: begin
                w_state_next = ST_FETCH;
                w_retire     = 1'b1;
            end
            default: w_state_next = ST_FETCH;
        endcase
    end

    // Retired-instruction counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)         r_count <= '0;
        else if (w_retire) r_count <= r_count + CNT_W'(1);
    end

    main_ctrl_decode u_decode (
        .i_state (r_state),
        .o_ctrl  (w_ctrl)
    );

    // Reset forces every output low, even though FETCH is already loaded.
    assign w_ctrl_g   = reset ? CTRL_IDLE : w_ctrl;

    assign PCEn       = w_ctrl_g.pc_write | (w_ctrl_g.pc_write_cond & Zero);
    assign IorD       = w_ctrl_g.iord;
    assign MemRead    = w_ctrl_g.mem_read;
    assign MemWrite   = w_ctrl_g.mem_write;
    assign IRWrite    = w_ctrl_g.ir_write;
    assign MemtoReg   = w_ctrl_g.mem_to_reg;
    assign RegDst     = w_ctrl_g.reg_dst;
    assign RegWrite   = w_ctrl_g.reg_write;
    assign ALUSrcA    = w_ctrl_g.alu_src_a;
    assign ALUSrcB    = w_ctrl_g.alu_src_b;
    assign PCSource   = w_ctrl_g.pc_source;
    assign InOp       = w_ctrl_g.in_op;
    assign IllegalOp  = w_illegal & ~reset;
    assign InstrCount = r_count;
    assign State      = reset ? 4'd0 : 4'(r_state);

endmodule

// File: tb/tb_multicycle_main_control.sv
module tb_multicycle_main_control;

    localparam logic [5:0] RT  = 6'b000000;
    localparam logic [5:0] LW  = 6'b100011;
    localparam logic [5:0] SW  = 6'b101011;
    localparam logic [5:0] BEQ = 6'b000100;
    localparam logic [5:0] JMP = 6'b000010;
    localparam logic [5:0] ADI = 6'b001000;
    localparam logic [5:0] BAD = 6'b111111;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  Opcode;
    logic        Zero;
    logic        PCEn, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA;
    logic [1:0]  ALUSrcB, PCSource;
    logic [2:0]  InOp;
    logic        IllegalOp;
    logic [15:0] InstrCount;
    logic [3:0]  State;

    // Narrow-counter instance sharing all inputs, to observe wrap-around.
    logic        n_PCEn, n_IorD, n_MemRead, n_MemWrite, n_IRWrite, n_MemtoReg, n_RegDst;
    logic        n_RegWrite, n_ALUSrcA, n_IllegalOp;
    logic [1:0]  n_ALUSrcB, n_PCSource, n_InstrCount;
    logic [2:0]  n_InOp;
    logic [3:0]  n_State;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    multicycle_main_control #(.CNT_W(16)) u_dut (
        .clk(clk), .reset(reset), .Opcode(Opcode), .Zero(Zero),
        .PCEn(PCEn), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
        .IRWrite(IRWrite), .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSource(PCSource), .InOp(InOp),
        .IllegalOp(IllegalOp), .InstrCount(InstrCount), .State(State)
    );

    multicycle_main_control #(.CNT_W(2)) u_dut_narrow (
        .clk(clk), .reset(reset), .Opcode(Opcode), .Zero(Zero),
        .PCEn(n_PCEn), .IorD(n_IorD), .MemRead(n_MemRead), .MemWrite(n_MemWrite),
        .IRWrite(n_IRWrite), .MemtoReg(n_MemtoReg), .RegDst(n_RegDst), .RegWrite(n_RegWrite),
        .ALUSrcA(n_ALUSrcA), .ALUSrcB(n_ALUSrcB), .PCSource(n_PCSource), .InOp(n_InOp),
        .IllegalOp(n_IllegalOp), .InstrCount(n_InstrCount), .State(n_State)
    );

    typedef struct {
        logic        rst;
        logic [5:0]  op;
        logic        zero;
        logic [3:0]  st;
        logic        pcen, mrd, mwr, irw, rgw, ill, m2r, rdst;
        logic [2:0]  inop;
        logic [1:0]  psrc;
        logic [15:0] cnt;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(input logic rst, input logic [5:0] op, input logic zero,
                                input logic [3:0] st, input logic pcen, input logic mrd,
                                input logic mwr, input logic irw, input logic rgw,
                                input logic ill, input logic m2r, input logic rdst,
                                input logic [2:0] inop, input logic [1:0] psrc,
                                input logic [15:0] cnt);
        vec_t v;
        v.rst = rst; v.op = op; v.zero = zero; v.st = st; v.pcen = pcen; v.mrd = mrd;
        v.mwr = mwr; v.irw = irw; v.rgw = rgw; v.ill = ill; v.m2r = m2r; v.rdst = rdst;
        v.inop = inop; v.psrc = psrc; v.cnt = cnt;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [15:0] act,
                       input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s step=%0d got=%0h expected=%0h", name, idx, act, exp);
        end
    endtask

    initial begin
        reset  = 1'b1;
        Opcode = RT;
        Zero   = 1'b0;

        //            rst op  z  st pc mr mw ir rw il m2 rd inop    psrc   cnt
        // reset held three cycles
        repeat (3) vq.push_back(mk(1, RT, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 2'b00, 0));
        // R-type: 0,1,6,7 (opcode changes in EXEC/RWB must be ignored)
        vq.push_back(mk(0, RT,  0, 0, 1, 1, 0, 1, 0, 0, 0, 0, 3'b001, 2'b00, 0));
        vq.push_back(mk(0, RT,  0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 3'b001, 2'b00, 0));
        vq.push_back(mk(0, BAD, 0, 6, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 2'b00, 0));
        vq.push_back(mk(0, BAD, 0, 7, 0, 0, 0, 0, 1, 0, 0, 1, 3'b000, 2'b00, 0));
        // lw: 0,1,2,3,4
        vq.push_back(mk(0, LW,  0, 0, 1, 1, 0, 1, 0, 0, 0, 0, 3'b001, 2'b00, 1));
        vq.push_back(mk(0, LW,  0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 3'b001, 2'b00, 1));
        vq.push_back(mk(0, LW,  0, 2, 0, 0, 0, 0, 0, 0, 0, 0, 3'b001, 2'b00, 1));
        vq.push_back(mk(0, LW,  0, 3, 0, 1, 0, 0, 0, 0, 0, 0, 3'b000, 2'b00, 1));
        vq.push_back(mk(0, LW,  0, 4, 0, 0, 0, 0, 1, 0, 1, 0, 3'b000, 2'b00, 1));
        // sw: 0,1,2,5
        vq.push_back(mk(0, SW,  0, 0, 1, 1, 0, 1, 0, 0, 0, 0, 3'b001, 2'b00, 2));
        vq.push_back(mk(0, SW,  0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 3'b001, 2'b00, 2));
        vq.push_back(mk(0, SW,  0, 2, 0, 0, 0, 0, 0, 0, 0, 0, 3'b001, 2'b00, 2));
        vq.push_back(mk(0, SW,  0, 5, 0, 0, 1, 0, 0, 0, 0, 0, 3'b000, 2'b00, 2));
        // beq taken
        vq.push_back(mk(0, BEQ, 1, 0, 1, 1, 0, 1, 0, 0, 0, 0, 3'b001, 2'b00, 3));
        vq.push_back(mk(0, BEQ, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 3'b001, 2'b00, 3));
        vq.push_back(mk(0, BEQ, 1, 8, 1, 0, 0, 0, 0, 0, 0, 0, 3'b010, 2'b01, 3));
        // beq not taken
        vq.push_back(mk(0, BEQ, 0, 0, 1, 1, 0, 1, 0, 0, 0, 0, 3'b001, 2'b00, 4));
        vq.push_back(mk(0, BEQ, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 3'b001, 2'b00, 4));
        vq.push_back(mk(0, BEQ, 0, 8, 0, 0, 0, 0, 0, 0, 0, 0, 3'b010, 2'b01, 4));
        // illegal opcode: pulse in DECODE, back to FETCH, no retire
        vq.push_back(mk(0, BAD, 0, 0, 1, 1, 0, 1, 0, 0, 0, 0, 3'b001, 2'b00, 5));
        vq.push_back(mk(0, BAD, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 3'b001, 2'b00, 5));
        // j
        vq.push_back(mk(0, JMP, 0, 0, 1, 1, 0, 1, 0, 0, 0, 0, 3'b001, 2'b00, 5));
        vq.push_back(mk(0, JMP, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 3'b001, 2'b00, 5));
        vq.push_back(mk(0, JMP, 0, 9, 1, 0, 0, 0, 0, 0, 0, 0, 3'b000, 2'b10, 5));
        // addi: 0,1,10,11
        vq.push_back(mk(0, ADI, 0, 0,  1, 1, 0, 1, 0, 0, 0, 0, 3'b001, 2'b00, 6));
        vq.push_back(mk(0, ADI, 0, 1,  0, 0, 0, 0, 0, 0, 0, 0, 3'b001, 2'b00, 6));
        vq.push_back(mk(0, ADI, 0, 10, 0, 0, 0, 0, 0, 0, 0, 0, 3'b001, 2'b00, 6));
        vq.push_back(mk(0, ADI, 0, 11, 0, 0, 0, 0, 1, 0, 0, 0, 3'b000, 2'b00, 6));
        vq.push_back(mk(0, SW,  0, 0,  1, 1, 0, 1, 0, 0, 0, 0, 3'b001, 2'b00, 7));

        foreach (vq[i]) begin
            reset  = vq[i].rst;
            Opcode = vq[i].op;
            Zero   = vq[i].zero;
            @(negedge clk);
            chk("State",      i, 16'(State),      16'(vq[i].st));
            chk("PCEn",       i, 16'(PCEn),       16'(vq[i].pcen));
            chk("MemRead",    i, 16'(MemRead),    16'(vq[i].mrd));
            chk("MemWrite",   i, 16'(MemWrite),   16'(vq[i].mwr));
            chk("IRWrite",    i, 16'(IRWrite),    16'(vq[i].irw));
            chk("RegWrite",   i, 16'(RegWrite),   16'(vq[i].rgw));
            chk("IllegalOp",  i, 16'(IllegalOp),  16'(vq[i].ill));
            chk("MemtoReg",   i, 16'(MemtoReg),   16'(vq[i].m2r));
            chk("RegDst",     i, 16'(RegDst),     16'(vq[i].rdst));
            chk("InOp",       i, 16'(InOp),       16'(vq[i].inop));
            chk("PCSource",   i, 16'(PCSource),   16'(vq[i].psrc));
            chk("InstrCount", i, InstrCount,      vq[i].cnt);
            chk("CountWrap",  i, 16'(n_InstrCount), 16'(vq[i].cnt[1:0]));
            @(posedge clk);
            #1;
        end

        // sw interrupted by reset while in MEMWR (now in DECODE with Opcode=SW)
        @(posedge clk); #1;              // -> MEMADR
        @(posedge clk); #1;              // -> MEMWR
        @(negedge clk);
        chk("sw_mid_State",    100, 16'(State),    16'd5);
        chk("sw_mid_MemWrite", 100, 16'(MemWrite), 16'd1);
        chk("sw_mid_IorD",     100, 16'(IorD),     16'd1);
        chk("sw_mid_Count",    100, InstrCount,    16'd7);
        reset = 1'b1;
        #1;
        chk("rst_MemWrite", 101, 16'(MemWrite),   16'd0);
        chk("rst_State",    101, 16'(State),      16'd0);
        chk("rst_Count",    101, InstrCount,      16'd0);
        chk("rst_PCEn",     101, 16'(PCEn),       16'd0);
        chk("rst_MemRead",  101, 16'(MemRead),    16'd0);
        @(posedge clk); #1;
        chk("rst_hold_Count", 102, InstrCount,    16'd0);
        chk("rst_hold_Wrap",  102, 16'(n_InstrCount), 16'd0);
        reset  = 1'b0;
        Opcode = RT;
        @(negedge clk);
        chk("rel_State",   103, 16'(State),   16'd0);
        chk("rel_MemRead", 103, 16'(MemRead), 16'd1);
        chk("rel_IRWrite", 103, 16'(IRWrite), 16'd1);
        @(posedge clk); #1;
        chk("rel_next_State", 104, 16'(State),   16'd1);
        chk("rel_next_Count", 104, InstrCount,   16'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
